seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//   Eight-digit multiplexed 7-segment display controller, downstream of the CPU core.
//   The CPU writes a 32-bit display word and a control word over a simple write port.
//   The block shows the word as 8 hex digits on o_seg/o_sel, scanning one digit at a time.
//   Data writes are double-buffered and committed only at frame boundaries, so no frame tears.
// PARAMETERS
//   SCAN_DIV  100000  clk cycles each digit is lit (>=2); frame = 8*SCAN_DIV cycles
// PORTS
//   clk         in   1   system clock, all logic on posedge
//   rst         in   1   synchronous reset, active-high
//   wr_en       in   1   write strobe, one cycle per write
//   wr_addr     in   1   0 = data register, 1 = control register
//   wr_data     in   32  write data
//   o_seg       out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   o_sel       out  8   digit enables, active-low, one-hot; bit i = digit i (nibble i)
//   frame_done  out  1   one-cycle pulse at end of each scan frame
// BEHAVIOUR
//   Interface: one clock (clk); rst is synchronous, active-high.
//   Reset values: div=0, idx=0, shadow=0, disp=0, pending=0.
//     ctrl: en=1, lz=0, dp_mask=0. Outputs: o_seg=8'hFF, o_sel=8'hFF, frame_done=0.
//   Control word (wr_addr=1): [0] en, [1] lz (leading-zero blank), [15:8] dp_mask.
//     Other bits are ignored. A control write takes effect on the next edge; it is not buffered.
//   Data write (wr_addr=0): shadow<=wr_data, pending<=1. The displayed word disp is unchanged.
//   Scan: div counts 0..SCAN_DIV-1. On div==SCAN_DIV-1, div wraps to 0 and idx increments (7->0).
//   frame_tick = (div==SCAN_DIV-1 && idx==7).
//     On that edge: frame_done<=1 for one cycle; if pending, disp<=shadow and pending<=0.
//   Simultaneous data write and frame_tick:
//     disp takes the shadow value from before the edge; shadow takes wr_data; pending stays 1.
//     The new word is shown from the following frame.
//   Outputs are registered, computed each cycle from current idx/disp/ctrl.
//     They follow an idx change by one cycle.
//   Hex decode (g..a, active-low) for nibble n = disp[4*idx+:4]:
//     0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
//     8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
//     o_seg[7] = ~dp_mask[idx]. o_sel = ~(8'b1<<idx).
//   Leading-zero blank (lz=1): digit i>0 is blanked if disp[31:4*i]==0. Digit 0 is never blanked.
//   Blanked digit or en=0: o_seg=8'hFF, o_sel=8'hFF. Blanking overrides dp.
//     Scanning, frame_tick and commits continue while en=0.
//   Reset mid-scan: all state returns to reset values on the next edge.
//     A pending write is discarded.
// TESTING  (bench uses SCAN_DIV=4)
//   1 Reset then release:
//     rst=1 2 cycles -> o_seg=FF, o_sel=FF.
//     1st edge after release -> o_sel=FE, o_seg=C0.
//   2 Data write, commit at frame boundary:
//     write data 32'h1234ABCD -> display shows old value until frame_done.
//     Next frame: idx0 sel FE seg A1; idx1 FD C6; idx4 EF 99; idx7 7F F9.
//     frame_done pulses every 32 cycles.
//   3 Leading-zero blank with dp:
//     ctrl=32'h0000_0103 (en, lz, dp on digit 0); data=32'h00000005.
//     Digit0 -> seg 12, sel FE. Digits 1..7 -> FF/FF.
//     data=0 -> digit0 seg 40 (C0 with dp lit).
//   4 Write on frame_tick edge:
//     pending A=32'h11111111, write B=32'h22222222 on the frame_tick cycle.
//     Next frame shows all digits F9; following frame shows all A4.
//   5 en=0 mid-frame:
//     o_seg/o_sel = FF/FF from next edge; frame_done keeps pulsing every 32 cycles.
//     en=1 resumes at the current idx.
//   6 Reset mid-scan at idx=5 with pending write:
//     next edge o_seg/o_sel=FF, idx=0.
//     After release the display shows 0 (C0 on digit 0); the discarded word never appears.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed hex display scanner with frame-synchronous double-buffered data.
// Latency: outputs registered, one cycle behind idx/disp/ctrl; data commits at frame end.
// Backpressure: none; writes always accepted, later data writes overwrite the shadow word.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_addr,
    input  logic [31:0] wr_data,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef struct packed {
        logic [7:0] dp_mask;
        logic       lz;
        logic       en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{dp_mask: 8'h00, lz: 1'b0, en: 1'b1};

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic [31:0]      disp;
    logic             pending;
    ctrl_t            ctrl;

    logic             frame_tick;
    logic [3:0]       nibble;
    logic [31:0]      upper;
    logic             blank;
    logic [6:0]       hex_seg;
    logic [7:0]       seg_nxt;
    logic [7:0]       sel_nxt;

    always_comb begin
        frame_tick = (div == DIV_LAST) && (idx == 3'd7);
    end

    // upper holds the current digit and everything above it; zero means a leading zero.
    always_comb begin
        nibble = disp[{idx, 2'b00} +: 4];
        upper  = disp >> {idx, 2'b00};
        blank  = !ctrl.en || (ctrl.lz && (idx != 3'd0) && (upper == 32'd0));
    end

    always_comb begin
        hex_seg = 7'h7F;
        case (nibble)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    always_comb begin
        seg_nxt = 8'hFF;
        sel_nxt = 8'hFF;
        if (!blank) begin
            seg_nxt = {~ctrl.dp_mask[idx], hex_seg};
            sel_nxt = ~(8'd1 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= 3'd0;
            shadow     <= 32'd0;
            disp       <= 32'd0;
            pending    <= 1'b0;
            ctrl       <= CTRL_RST;
            o_seg      <= 8'hFF;
            o_sel      <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 3'd1;
            end else begin
                div <= div + DIV_W'(1);
            end

            frame_done <= frame_tick;

            // A data write landing on the tick edge still sees the old shadow committed,
            // and the later assignment below keeps pending set for the next frame.
            if (frame_tick && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            if (wr_en && !wr_addr) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end
            if (wr_en && wr_addr) begin
                ctrl <= '{dp_mask: wr_data[15:8], lz: wr_data[1], en: wr_data[0]};
            end

            o_seg <= seg_nxt;
            o_sel <= sel_nxt;
        end
    end

endmodule
